// File: rtl/quality_grader.sv
// Item grader: a 3-sample per-bit majority vote over N_CRIT criteria, a LOW/MEDIUM/HIGH grade shown on
// the LEDs for HOLD_CYCLES cycles, and saturating per-grade production counters.
module quality_grader #(
    parameter int N_CRIT      = 3,
    parameter int MED_TH      = 2,
    parameter int HIGH_TH     = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start_i,
    input  logic [N_CRIT-1:0] crit_i,
    input  logic              clr_cnt_i,
    input  logic [1:0]        cnt_sel_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [1:0]        grade_o,
    output logic              led_low_o,
    output logic              led_medium_o,
    output logic              led_high_o,
    output logic [CNT_W-1:0]  cnt_o
);

    localparam int PC_W  = $clog2(N_CRIT + 1);
    localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_EVAL, S_HOLD} state_t;

    state_t             r_state, w_next;
    logic [N_CRIT-1:0]  r_s0, r_s1, r_s2;
    logic               r_cap_idx;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_valid;
    logic [1:0]         r_grade;
    logic [2:0]         r_led;
    logic [CNT_W-1:0]   r_cnt [4];

    logic [N_CRIT-1:0]  w_maj;
    logic [PC_W-1:0]    w_pc;
    logic [1:0]         w_grade;
    logic               w_eval_fire;
    logic               w_hold_done;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next state; every transition is gated by ena
    always_comb begin
        w_next = r_state;
        if (ena) begin
            case (r_state)
                S_IDLE:    if (start_i) w_next = S_CAPTURE;
                S_CAPTURE: if (r_cap_idx) w_next = S_EVAL;
                S_EVAL:    w_next = S_HOLD;
                S_HOLD:    if (r_tmr == '0) w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy_o      = (r_state != S_IDLE);
        w_eval_fire = ena && (r_state == S_EVAL);
        w_hold_done = ena && (r_state == S_HOLD) && (r_tmr == '0);
    end

    assign w_maj = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < N_CRIT; i++) w_pc = w_pc + PC_W'(w_maj[i]);
    end

    always_comb begin
        if (w_pc >= PC_W'(HIGH_TH))     w_grade = 2'b11;
        else if (w_pc >= PC_W'(MED_TH)) w_grade = 2'b10;
        else                            w_grade = 2'b01;
    end

    // Sample capture: s0 on the accepted start, then s1 and s2 on the next two enabled edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0      <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
            r_cap_idx <= 1'b0;
        end else if (ena) begin
            if (r_state == S_IDLE && start_i) begin
                r_s0      <= crit_i;
                r_cap_idx <= 1'b0;
            end else if (r_state == S_CAPTURE) begin
                if (!r_cap_idx) r_s1 <= crit_i;
                else            r_s2 <= crit_i;
                r_cap_idx <= 1'b1;
            end
        end
    end

    // Grade, LEDs and hold timer; valid_o clears on the following edge even when ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_grade <= 2'b00;
            r_led   <= 3'b000;
            r_tmr   <= '0;
        end else begin
            r_valid <= w_eval_fire;
            if (w_eval_fire) begin
                r_grade <= w_grade;
                r_led   <= {w_grade == 2'b11, w_grade == 2'b10, w_grade == 2'b01};
                r_tmr   <= TMR_W'(HOLD_CYCLES - 1);
            end else if (w_hold_done) begin
                r_led   <= 3'b000;
            end else if (ena && r_state == S_HOLD) begin
                r_tmr   <= r_tmr - TMR_W'(1);
            end
        end
    end

    // Counters 0..2 follow grade codes 01..11; counter 3 is TOTAL. Clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else if (clr_cnt_i) begin
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else if (w_eval_fire) begin
            for (int k = 0; k < 4; k++) begin
                if ((k == 3 || 2'(k) == w_grade - 2'd1) && r_cnt[k] != '1)
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
        end
    end

    assign valid_o      = r_valid;
    assign grade_o      = r_grade;
    assign led_low_o    = r_led[0];
    assign led_medium_o = r_led[1];
    assign led_high_o   = r_led[2];
    assign cnt_o        = r_cnt[cnt_sel_i];

endmodule

// File: tb/tb_quality_grader.sv
// Directed bench: a default instance, a CNT_W=2 instance and a 5-criteria instance share one stimulus stream.
module tb_quality_grader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [2:0] crit;
    logic [4:0] crit5;
    logic       clr;
    logic [1:0] sel;

    logic       a_busy, a_valid, a_lo, a_me, a_hi;
    logic [1:0] a_grade;
    logic [7:0] a_cnt;
    logic       b_busy, b_valid, b_lo, b_me, b_hi;
    logic [1:0] b_grade;
    logic [1:0] b_cnt;
    logic       c_busy, c_valid, c_lo, c_me, c_hi;
    logic [1:0] c_grade;
    logic [7:0] c_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int ea[4];
    int eb[4];

    always #10 clk = ~clk;

    quality_grader dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start_i(start), .crit_i(crit),
        .clr_cnt_i(clr), .cnt_sel_i(sel), .busy_o(a_busy), .valid_o(a_valid),
        .grade_o(a_grade), .led_low_o(a_lo), .led_medium_o(a_me), .led_high_o(a_hi),
        .cnt_o(a_cnt)
    );

    quality_grader #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start_i(start), .crit_i(crit),
        .clr_cnt_i(clr), .cnt_sel_i(sel), .busy_o(b_busy), .valid_o(b_valid),
        .grade_o(b_grade), .led_low_o(b_lo), .led_medium_o(b_me), .led_high_o(b_hi),
        .cnt_o(b_cnt)
    );

    quality_grader #(.N_CRIT(5), .MED_TH(3), .HIGH_TH(5)) dut_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start_i(start), .crit_i(crit5),
        .clr_cnt_i(clr), .cnt_sel_i(sel), .busy_o(c_busy), .valid_o(c_valid),
        .grade_o(c_grade), .led_low_o(c_lo), .led_medium_o(c_me), .led_high_o(c_hi),
        .cnt_o(c_cnt)
    );

    typedef struct {
        logic [2:0] c0;
        logic [2:0] c1;
        logic [2:0] c2;
        logic [1:0] g;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bump(input logic [1:0] g);
        int k;
        k = int'(g) - 1;
        ea[k]++; ea[3]++;
        if (eb[k] < 3) eb[k]++;
        if (eb[3] < 3) eb[3]++;
    endtask

    task automatic zero_model();
        for (int k = 0; k < 4; k++) begin ea[k] = 0; eb[k] = 0; end
    endtask

    task automatic chk_cnts(input string nm);
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            check({nm, "_cntA"}, 32'(a_cnt), 32'(ea[k]));
            check({nm, "_cntB"}, 32'(b_cnt), 32'(eb[k]));
        end
        sel = 2'd3;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!a_busy) return;
        end
        check({nm, "_idle_timeout"}, 32'(a_busy), 32'd0);
    endtask

    // One item from an IDLE start; T0 is the first posedge after the start is driven
    task automatic run_item(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                            input logic [1:0] eg, input string nm);
        @(negedge clk); start = 1'b1; crit = c0;
        @(negedge clk); start = 1'b0; crit = c1;
        check({nm, "_busy_T0"}, 32'(a_busy), 32'd1);
        @(negedge clk); crit = c2;
        @(negedge clk);
        check({nm, "_novalid_T2"}, 32'(a_valid), 32'd0);
        @(negedge clk);
        check({nm, "_valid_T3"}, 32'(a_valid), 32'd1);
        check({nm, "_grade"}, 32'(a_grade), 32'(eg));
        check({nm, "_gradeB"}, 32'(b_grade), 32'(eg));
        check({nm, "_gradeC"}, 32'(c_grade), 32'd2);
        check({nm, "_leds"}, 32'({a_hi, a_me, a_lo}), 32'({eg == 2'b11, eg == 2'b10, eg == 2'b01}));
        bump(eg);
        sel = 2'd3; #1;
        check({nm, "_total_T3"}, 32'(a_cnt), 32'(ea[3]));
        repeat (3) @(negedge clk);
        check({nm, "_leds_T6"}, 32'({a_hi, a_me, a_lo}), 32'({eg == 2'b11, eg == 2'b10, eg == 2'b01}));
        check({nm, "_busy_T6"}, 32'(a_busy), 32'd1);
        @(negedge clk);
        check({nm, "_busy_T7"}, 32'(a_busy), 32'd0);
        check({nm, "_leds_T7"}, 32'({a_hi, a_me, a_lo}), 32'd0);
        check({nm, "_grade_T7"}, 32'(a_grade), 32'(eg));
    endtask

    initial begin
        int vcnt, v0, v1;

        tbl[0] = '{3'b111, 3'b111, 3'b111, 2'b11};
        tbl[1] = '{3'b111, 3'b011, 3'b111, 2'b11};
        tbl[2] = '{3'b011, 3'b111, 3'b001, 2'b10};
        tbl[3] = '{3'b000, 3'b000, 3'b000, 2'b01};
        tbl[4] = '{3'b100, 3'b010, 3'b001, 2'b01};
        tbl[5] = '{3'b110, 3'b101, 3'b011, 2'b11};

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; crit = '0; crit5 = 5'b11110;
        clr = 1'b0; sel = 2'd3;
        zero_model();
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_grade", 32'(a_grade), 32'd0);
        check("rst_leds", 32'({a_hi, a_me, a_lo}), 32'd0);
        chk_cnts("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_item(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].g, $sformatf("vec%0d", i));
        chk_cnts("table");

        // Clear on the EVAL edge wins over the increment
        @(negedge clk); start = 1'b1; crit = 3'b111;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        check("clr_valid", 32'(a_valid), 32'd1);
        zero_model();
        chk_cnts("clr_eval");
        wait_idle("clr");

        // start held high: one evaluation every 8 cycles
        vcnt = 0; v0 = -1; v1 = -1;
        @(negedge clk); start = 1'b1; crit = 3'b111;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (a_valid) begin
                if (vcnt == 0) v0 = i; else v1 = i;
                vcnt++;
            end
            if (i == 7) check("held_busy_T7", 32'(a_busy), 32'd0);
        end
        start = 1'b0;
        check("held_count", 32'(vcnt), 32'd2);
        check("held_first", 32'(v0), 32'd3);
        check("held_second", 32'(v1), 32'd11);
        bump(2'b11); bump(2'b11);
        wait_idle("held");
        chk_cnts("held");

        // ena low for 3 cycles mid-CAPTURE; frozen edges see all-zero criteria
        @(negedge clk); start = 1'b1; crit = 3'b111; crit5 = 5'b11110;
        @(negedge clk); start = 1'b0; ena = 1'b0; crit = 3'b000; crit5 = 5'b00000;
        repeat (3) @(negedge clk);
        ena = 1'b1; crit = 3'b111; crit5 = 5'b11110;
        @(negedge clk);
        @(negedge clk);
        check("ena_novalid_T5", 32'(a_valid), 32'd0);
        @(negedge clk);
        check("ena_valid_T6", 32'(a_valid), 32'd1);
        check("ena_grade", 32'(a_grade), 32'd3);
        check("ena_gradeC", 32'(c_grade), 32'd2);
        check("ena_ledC", 32'({c_hi, c_me, c_lo}), 32'b010);
        @(negedge clk);
        check("ena_valid_T7", 32'(a_valid), 32'd0);
        bump(2'b11);
        wait_idle("ena");

        run_item(3'b111, 3'b111, 3'b111, 2'b11, "sat");
        chk_cnts("sat");

        // Reset asserted mid-HOLD
        @(negedge clk); start = 1'b1; crit = 3'b111;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0; #1;
        check("rsth_leds", 32'({a_hi, a_me, a_lo}), 32'd0);
        check("rsth_grade", 32'(a_grade), 32'd0);
        check("rsth_busy", 32'(a_busy), 32'd0);
        zero_model();
        chk_cnts("rsth");
        @(negedge clk); rst_n = 1'b1;
        run_item(3'b111, 3'b111, 3'b111, 2'b11, "after_rst");
        chk_cnts("after_rst");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
